// File: rtl/pci_pkg.sv
// Shared definitions for the burst-capable PCI memory target: bus commands,
// target state encoding and address-window helpers.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_TURN,
    RD_DATA,
    DISC,
    BACKOFF
  } state_e;

  // Window size in bytes, one bit wider than the bus so a window ending at 4 GiB still fits.
  function automatic logic [32:0] window_bytes(input int unsigned depth);
    return 33'(depth) * 33'(BYTES_PER_WORD);
  endfunction

  function automatic logic [32:0] window_end(input logic [31:0] base, input int unsigned depth);
    return {1'b0, base} + window_bytes(depth);
  endfunction

endpackage

// File: rtl/pci_target_mem.sv
// Word-wide storage for the PCI target: byte-enabled synchronous write,
// asynchronous read on the same index.
module pci_target_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int          IW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // NOTE: the array has no reset; contents must survive RST, and a reset would prevent RAM mapping.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/pci_burst_target.sv
// PCI memory target with address-window decode, linear read/write bursts and byte enables.
// Define PCI_TARGET_DISCONNECT_EN to disconnect at the window end instead of wrapping.
module pci_burst_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  output logic        TRDY,
  output logic        DEVSEL,
  output logic        STOP
);

  localparam int                IW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IW-1:0]     LAST_IDX  = IW'(MEM_DEPTH - 1);
  localparam logic [32:0]       WIN_BYTES = window_bytes(MEM_DEPTH);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [32:0]   diff;
  logic          hit;
  logic          xfer;
  logic          mem_we;
  logic          ad_oe;
  logic [31:0]   rd_word;

  // A borrow out of the subtraction means the address lies below the window.
  assign diff = {1'b0, AD} - {1'b0, BASE_ADDR};
  assign hit  = !diff[32] && ({1'b0, diff[31:0]} < WIN_BYTES);
  assign xfer = !IRDY && !TRDY;

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (!FRAME && hit) begin
          if (CBE == CMD_MEM_WRITE) begin
            state_d = WR_DATA;
            idx_d   = diff[IW+1:2];
          end else if (CBE == CMD_MEM_READ) begin
            state_d = RD_TURN;
            idx_d   = diff[IW+1:2];
          end
        end
      end
      WR_DATA, RD_DATA: begin
        if (xfer) begin
          if (FRAME) begin
            state_d = BACKOFF;
          end else begin
`ifdef PCI_TARGET_DISCONNECT_EN
            if (idx_q == LAST_IDX) state_d = DISC;
            else                   idx_d   = idx_q + 1'b1;
`else
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`endif
          end
        end else if (FRAME && IRDY) begin
          state_d = BACKOFF;
        end
      end
      RD_TURN: state_d = RD_DATA;
      DISC:    if (FRAME) state_d = BACKOFF;
      BACKOFF: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TRDY   = 1'b1;
    DEVSEL = 1'b1;
    STOP   = 1'b1;
    ad_oe  = 1'b0;
    unique case (state_q)
      WR_DATA: begin
        DEVSEL = 1'b0;
        TRDY   = 1'b0;
      end
      RD_TURN: DEVSEL = 1'b0;
      RD_DATA: begin
        DEVSEL = 1'b0;
        TRDY   = 1'b0;
        ad_oe  = 1'b1;
      end
      DISC: begin
        DEVSEL = 1'b0;
`ifdef PCI_TARGET_DISCONNECT_EN
        STOP   = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // The reset edge itself never commits a write, so an aborted burst keeps only earlier words.
  assign mem_we = (state_q == WR_DATA) && xfer && !RST;

  pci_target_mem #(
    .DEPTH (MEM_DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .be    (~CBE),
    .addr  (idx_q),
    .wdata (AD),
    .rdata (rd_word)
  );

  assign AD = ad_oe ? rd_word : {32{1'bz}};

endmodule

// File: doc/pci_burst_target.md
# pci_burst_target

Parametrised PCI memory target: decodes a configurable address window, accepts memory-read and memory-write bursts of any length with per-byte enables, inserts the read turnaround cycle, and honours initiator wait states. Sits on the shared FRAME/IRDY/TRDY/DEVSEL/AD/CBE bus beside other targets and the initiator model. It is the successor to the single-word device, adding bursts, byte masking, address-window decode and target disconnect.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
- MEM_DEPTH, 256, number of 32-bit words (window size = 4*MEM_DEPTH bytes); index width IW = $clog2(MEM_DEPTH)
- CLK  in  1  bus clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- FRAME  in  1  active-low transaction frame
- IRDY  in  1  active-low initiator ready
- CBE  in  4  command in the address phase; active-low byte enables in data phases
- AD  inout  32  multiplexed address/data; driven only while the read-data enable is set, else 'z
- TRDY  out  1  active-low target ready
- DEVSEL  out  1  active-low device select
- STOP  out  1  active-low target disconnect request

## Operation
- States: IDLE, WR_DATA, RD_TURN, RD_DATA, DISC, BACKOFF.
- IDLE: an edge with FRAME=0 is the address phase. Hit = BASE_ADDR <= AD < BASE_ADDR+4*MEM_DEPTH. idx <= (AD-BASE_ADDR)>>2 (AD[1:0] ignored; linear burst only).
  - Hit with CBE=4'b0111 -> WR_DATA.
  - Hit with CBE=4'b0110 -> RD_TURN.
  - Miss or any other command: stay in IDLE with DEVSEL high (master abort by initiator).
- Transfer = edge with IRDY=0 and TRDY=0. IRDY=1 is a wait state: no change to idx or AD.
- WR_DATA: on each transfer, byte lane b of mem[idx] is written from AD[8b+7:8b] only where CBE[b]=0; then idx+1.
- RD_TURN: one cycle, AD undriven, TRDY=1 -> RD_DATA.
- RD_DATA: AD drives mem[idx] and CBE is ignored. After a transfer, idx+1 and AD shows the new word from the next cycle.
- Last data phase is a transfer with FRAME=1 -> BACKOFF.
- FRAME=1 and IRDY=1 while in a data state (initiator abandoned) -> BACKOFF.
- BACKOFF: DEVSEL, TRDY and STOP high, AD released -> IDLE next edge.
- End of window: a transfer at idx=MEM_DEPTH-1 with FRAME=0 is handled per the Configuration section.
- Memory contents are not cleared by RST.

## Timing
- Reset values (from the first edge with RST=1): TRDY=1, DEVSEL=1, STOP=1, AD released, state IDLE, idx=0.
- RST mid-burst aborts the burst at that edge. The memory keeps every byte written before the edge.
- Address phase at edge k: DEVSEL=0 after k (fast decode).
- Write: TRDY=0 after k; first data can be captured at k+1.
- Read: the cycle after k is turnaround. AD is driven and TRDY=0 after k+1; first data can be taken at k+2.
- Back-to-back words: one per clock while IRDY=0. Zero target wait states after the first word.
- DEVSEL, TRDY and STOP go high one cycle after the last transfer. AD is released the same edge.
- A new address phase is accepted at the earliest on the edge after BACKOFF.
- STOP and TRDY are never both low.

## Configuration
- PCI_TARGET_DISCONNECT_EN defined: after a transfer at idx=MEM_DEPTH-1 with FRAME=0, go to DISC.
  - In DISC: STOP=0, TRDY=1, DEVSEL=0, AD released, no further memory accesses.
  - DISC holds until FRAME=1 is sampled, then -> BACKOFF.
- Undefined: STOP is tied high. idx wraps MEM_DEPTH-1 -> 0 and the burst continues.

## Structure
- Package pci_pkg holds:
  - CMD_MEM_READ = 4'b0110 and CMD_MEM_WRITE = 4'b0111
  - the target state enum
  - localparam helpers for window-end computation
- Sub-module pci_target_mem: MEM_DEPTH x 32 array with a byte-enable write port and an asynchronous read port. The FSM, decode and AD tristate control stay in pci_burst_target.

## Test plan
- Reset, then single write to BASE_ADDR+8 of 32'hDEADBEEF with CBE=4'b0000 -> DEVSEL low one cycle after the address phase; mem[2]=32'hDEADBEEF; all outputs high two cycles after.
- Write 32'h11223344 with CBE=4'b1010 over mem[0]=0 -> mem[0]=32'h00220044. A following read burst of 4 words from BASE_ADDR returns mem[0..3]. AD is undriven during the turnaround, and the first TRDY=0 comes two cycles after the address phase.
- Read burst with IRDY high for 2 cycles mid-burst -> AD and idx held; no word skipped or duplicated.
- Address BASE_ADDR+4*MEM_DEPTH, and separately CBE=4'b0010 at BASE_ADDR -> DEVSEL stays high throughout; memory unchanged.
- Write burst of 3 words starting at idx MEM_DEPTH-2:
  - with PCI_TARGET_DISCONNECT_EN: STOP=0 after the second transfer; the third word is not written.
  - without it: the third word lands in mem[0].
- RST=1 asserted during the third word of a 6-word write -> outputs high the next cycle; words 0-1 are retained.
